// File: rtl/lcd_pkg.sv
// lcd_pkg: opcode masks, DDRAM address map and fill/busy state
// shared by the LCD bus responder and its DDRAM.
package lcd_pkg;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FSET  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam logic [6:0] AC_ROW0     = 7'h00;
  localparam logic [6:0] AC_ROW0_END = 7'h27;
  localparam logic [6:0] AC_ROW1     = 7'h40;
  localparam logic [6:0] AC_ROW1_END = 7'h67;
  localparam int         ROW_LEN     = 16;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic [1:0] {IDLE, FILL, BUSY} fill_state_e;

  // Address counter step with the two-row wrap points.
  function automatic logic [6:0] ac_step(
    input logic [6:0] ac,
    input logic       up
  );
    if (up) begin
      if (ac == AC_ROW0_END) return AC_ROW1;
      if (ac == AC_ROW1_END) return AC_ROW0;
      return ac + 7'd1;
    end
    if (ac == AC_ROW0) return AC_ROW1_END;
    if (ac == AC_ROW1) return AC_ROW0_END;
    return ac - 7'd1;
  endfunction

  // {valid, index}: only the visible 16 columns of each row are stored.
  function automatic logic [5:0] ac_map(input logic [6:0] ac);
    if (ac < AC_ROW0 + 7'(ROW_LEN))
      return {2'b10, ac[3:0]};
    if (ac >= AC_ROW1 && ac < AC_ROW1 + 7'(ROW_LEN))
      return {2'b11, ac[3:0]};
    return 6'd0;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32x8 character store, one write port and
// two registered read ports (bus side and mirror side).
module lcd_ddram (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] braddr_i,
  output logic [7:0] brdata_o,
  input  logic [4:0] mraddr_i,
  output logic [7:0] mrdata_o
);

  logic [7:0] mem_q [32];
  logic [7:0] bdat_q;
  logic [7:0] mdat_q;

  // Write port; reads in the same cycle see the old byte.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Both read ports registered, cleared while in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bdat_q <= 8'h00;
      mdat_q <= 8'h00;
    end else begin
      bdat_q <= mem_q[braddr_i];
      mdat_q <= mem_q[mraddr_i];
    end
  end

  assign brdata_o = bdat_q;
  assign mrdata_o = mdat_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style bus device with 16x2 DDRAM.
// Define LCD_NIBBLE_MODE_EN to enable 4-bit transfers.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] lcd_data_lcd_data,
  input  logic       lcd_enable_lcd_enable,
  input  logic       lcd_rs_lcd_rs,
  input  logic       lcd_rw_lcd_rw,
  output logic [7:0] lcd_rdata,
  output logic       lcd_rdata_oe,
  input  logic [4:0] char_rd_addr,
  output logic [7:0] char_rd_data,
  output logic       busy,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       err_pulse
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  logic [10:0] sync1_q, sync2_q;
  logic        e_prev_q;
  logic        st_fall_q, st_rise_q, st_rs_q, st_rw_q;
  logic [7:0]  st_data_q;

  fill_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  fidx_q, fidx_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic        disp_q, disp_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        oe_q, oe_d;
  logic        err_q;

  logic        busy_w, wr_fall, exec, err, slow, clr;
  logic [7:0]  exec_byte;
  logic        we_w;
  logic [4:0]  waddr_w;
  logic [7:0]  wdata_w, bus_rd;
  logic [5:0]  map_w;

  assign busy_w  = (state_q != IDLE);
  assign wr_fall = st_fall_q && !st_rw_q;
  assign map_w   = ac_map(ac_q);

  // Two-flop synchronizer on the whole bus, then registered E edges.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      e_prev_q  <= 1'b0;
      st_fall_q <= 1'b0;
      st_rise_q <= 1'b0;
      st_rs_q   <= 1'b0;
      st_rw_q   <= 1'b0;
      st_data_q <= '0;
    end else begin
      sync1_q   <= {lcd_enable_lcd_enable, lcd_rs_lcd_rs,
                    lcd_rw_lcd_rw, lcd_data_lcd_data};
      sync2_q   <= sync1_q;
      e_prev_q  <= sync2_q[10];
      st_fall_q <= e_prev_q & ~sync2_q[10];
      st_rise_q <= ~e_prev_q & sync2_q[10];
      st_rs_q   <= sync2_q[9];
      st_rw_q   <= sync2_q[8];
      st_data_q <= sync2_q[7:0];
    end
  end

`ifdef LCD_NIBBLE_MODE_EN
  logic       four_q, hi_q, fset;
  logic [3:0] nib_q;

  // Assemble nibble pairs; busy only gates the first half.
  always_comb begin
    exec      = 1'b0;
    err       = 1'b0;
    exec_byte = st_data_q;
    if (!four_q) begin
      exec = wr_fall && !busy_w;
      err  = wr_fall && busy_w;
    end else if (hi_q) begin
      err = wr_fall && busy_w;
    end else begin
      exec      = wr_fall;
      exec_byte = {nib_q, st_data_q[7:4]};
    end
    fset = exec && !st_rs_q && (exec_byte[7:5] == 3'b001);
  end

  // Bus width select and nibble phase tracking.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      four_q <= 1'b0;
      hi_q   <= 1'b1;
      nib_q  <= '0;
    end else if (fset) begin
      four_q <= ~exec_byte[4];
      hi_q   <= 1'b1;
    end else if (four_q && wr_fall && (!hi_q || !busy_w)) begin
      hi_q <= ~hi_q;
      if (hi_q) nib_q <= st_data_q[7:4];
    end
  end
`else
  assign exec      = wr_fall && !busy_w;
  assign err       = wr_fall && busy_w;
  assign exec_byte = st_data_q;
`endif

  // Fill/busy sequencing, instruction decode and read returns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    ac_d    = ac_q;
    id_d    = id_q;
    disp_d  = disp_q;
    rdata_d = rdata_q;
    oe_d    = oe_q;
    we_w    = 1'b0;
    waddr_w = fidx_q;
    wdata_w = FILL_CHAR;
    slow    = 1'b0;
    clr     = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    unique case (state_q)
      FILL: begin
        we_w   = 1'b1;
        fidx_d = fidx_q + 5'd1;
        if (fidx_q == 5'd31)
          state_d = (cnt_d != '0) ? BUSY : IDLE;
      end
      BUSY: if (cnt_d == '0) state_d = IDLE;
      default: ;
    endcase
    if (exec) begin
      if (st_rs_q) begin
        if (map_w[5]) begin
          we_w    = 1'b1;
          waddr_w = map_w[4:0];
          wdata_w = exec_byte;
        end
        ac_d = ac_step(ac_q, id_q);
      end else begin
        priority case (1'b1)
          |(exec_byte & OP_DDRAM): ac_d = exec_byte[6:0];
          |(exec_byte & OP_CGRAM): ;
          |(exec_byte & OP_FSET):  ;
          |(exec_byte & OP_SHIFT):
            if (!exec_byte[3]) ac_d = ac_step(ac_q, exec_byte[2]);
          |(exec_byte & OP_DISP):  disp_d = exec_byte[2];
          |(exec_byte & OP_ENTRY): id_d = exec_byte[1];
          |(exec_byte & OP_HOME): begin
            ac_d = '0;
            slow = 1'b1;
          end
          |(exec_byte & OP_CLEAR): begin
            ac_d = '0;
            id_d = 1'b1;
            slow = 1'b1;
            clr  = 1'b1;
          end
          default: ;
        endcase
      end
      cnt_d   = slow ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
      state_d = clr ? FILL : BUSY;
      if (clr) fidx_d = '0;
    end
    if (st_fall_q && st_rw_q && st_rs_q) ac_d = ac_step(ac_q, id_q);
    if (st_rise_q && st_rw_q) begin
      oe_d    = 1'b1;
      rdata_d = !st_rs_q ? {busy_w, ac_q} :
                map_w[5] ? bus_rd : FILL_CHAR;
    end else if (st_fall_q) begin
      oe_d = 1'b0;
    end
  end

  // Architectural state; reset restarts the DDRAM fill.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fidx_q  <= '0;
      ac_q    <= '0;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      err_q   <= err;
    end
  end

  lcd_ddram u_ddram (
    .clk_i    (clk_clk),
    .rst_i    (reset_reset),
    .we_i     (we_w),
    .waddr_i  (waddr_w),
    .wdata_i  (wdata_w),
    .braddr_i (map_w[4:0]),
    .brdata_o (bus_rd),
    .mraddr_i (char_rd_addr),
    .mrdata_o (char_rd_data)
  );

  assign lcd_rdata    = rdata_q;
  assign lcd_rdata_oe = oe_q;
  assign busy         = busy_w;
  assign cursor_addr  = ac_q;
  assign display_on   = disp_q;
  assign err_pulse    = err_q;

endmodule
